instruction_fetch: RTL and testbench

Fetch unit for the 4-bit core: the initiator side of the program ROM interface. Holds the program counter and drives ROM addresses. Accounts for the ROM's one-cycle registered read latency and buffers returned opcodes in a small tagged FIFO. Presents them to the decoder over a valid/ready handshake, with jump redirect and run/halt control.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instruction_fetch.sv | 80 ++++++++
 tb/tb_instruction_fetch.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit and decoder: bus widths, opcodes,
// the tagged instruction-buffer entry, and the run/halt control state.
package fetch_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;

    // Opcodes shared with the decoder
    localparam logic [DATA_W-1:0] LDA = 4'b0000;
    localparam logic [DATA_W-1:0] LDB = 4'b0001;
    localparam logic [DATA_W-1:0] LDO = 4'b0010;
    localparam logic [DATA_W-1:0] CLR = 4'b0111;
    localparam logic [DATA_W-1:0] XOR = 4'b1110;

    // Buffered instruction: opcode tagged with the address it came from
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] opcode;
    } fetch_entry_t;

    typedef enum logic {
        CTRL_HALT = 1'b0,
        CTRL_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: program ROM port, decoder valid/ready port, run and jump control.
//   master : fetch unit (drives romAddressOut, instrOut, instrPcOut, instrValid)
//   slave  : ROM / decoder / control side
interface instruction_fetch_if;
    import fetch_pkg::*;

    logic              runIn;
    logic [ADDR_W-1:0] romAddressOut;
    logic [DATA_W-1:0] romDataIn;
    logic [DATA_W-1:0] instrOut;
    logic [ADDR_W-1:0] instrPcOut;
    logic              instrValid;
    logic              instrReady;
    logic              jumpValid;
    logic [ADDR_W-1:0] jumpTarget;

    modport master (
        input  runIn, romDataIn, instrReady, jumpValid, jumpTarget,
        output romAddressOut, instrOut, instrPcOut, instrValid
    );

    modport slave (
        output runIn, romDataIn, instrReady, jumpValid, jumpTarget,
        input  romAddressOut, instrOut, instrPcOut, instrValid
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous tagged instruction FIFO with flush (flush beats push).
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : enqueue an entry; pop : dequeue head; flush : empty the FIFO
//   rdata      : head entry; valid : non-empty; occupancy : entry count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     rdata,
    output logic             valid,
    output logic [OCC_W-1:0] occupancy
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             do_pop_c;
    logic             do_push_c;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    assign do_pop_c  = pop && (count != '0);
    // A write into a full FIFO is only legal when the head leaves the same cycle
    assign do_push_c = push && ((count != OCC_W'(DEPTH)) || do_pop_c);

    // Storage, pointers and count
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop_c) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= OCC_W'(count + OCC_W'(1));
                2'b01:   count <= OCC_W'(count - OCC_W'(1));
                default: count <= count;
            endcase
        end
    end

    assign rdata     = mem[rd_ptr];
    assign valid     = (count != '0);
    assign occupancy = count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues ROM addresses under a credit check that
// accounts for the ROM's one-cycle read latency, and buffers tagged opcodes
// for the decoder. Supports jump redirect (flush) and run/halt.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instruction_fetch_if.master (ROM, decoder and control signals)
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_tag;
    logic [OCC_W-1:0]  occupancy;
    logic              pop_c;
    logic              issue_c;
    logic [OCC_W:0]    pending_c;
    ctrl_state_e       state_c;
    fetch_entry_t      push_entry_c;
    fetch_entry_t      head;

    // Run/halt only gates issue, so it follows runIn directly
    assign state_c = bus.runIn ? CTRL_RUN : CTRL_HALT;

    assign pop_c = bus.instrValid & bus.instrReady;

    // Entries the FIFO will hold once the in-flight read lands, after this cycle's pop
    assign pending_c = (OCC_W + 1)'(occupancy) + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop_c);

    assign issue_c = (state_c == CTRL_RUN) && !bus.jumpValid
                     && (pending_c < (OCC_W + 1)'(FIFO_DEPTH));

    // PC and in-flight tracking; jump wins over issue
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= '0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            if (bus.jumpValid) begin
                pc <= bus.jumpTarget;
            end else if (issue_c) begin
                pc <= ADDR_W'(pc + ADDR_W'(1));
            end
            inflight <= issue_c;
            if (issue_c) begin
                inflight_tag <= pc;
            end
        end
    end

    // A response arriving in the jump cycle is squashed by the flush taking priority
    assign push_entry_c = '{pc: inflight_tag, opcode: bus.romDataIn};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .wdata     (push_entry_c),
        .pop       (pop_c),
        .flush     (bus.jumpValid),
        .rdata     (head),
        .valid     (bus.instrValid),
        .occupancy (occupancy)
    );

    assign bus.romAddressOut = pc;
    assign bus.instrOut      = head.opcode;
    assign bus.instrPcOut    = head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a registered program ROM model.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   cyc;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] rom(input logic [3:0] a);
        case (a)
            4'd0:    return LDA;
            4'd1:    return LDB;
            4'd2:    return XOR;
            4'd3:    return LDO;
            default: return CLR;
        endcase
    endfunction

    // One-cycle registered ROM read
    always @(posedge clk) bus.romDataIn <= rom(bus.romAddressOut);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Apply reset, check reset state, release reset: caller is then in cycle 0
    task automatic start(input logic run, input logic rdy);
        @(negedge clk);
        reset          = 1'b1;
        bus.runIn      = run;
        bus.instrReady = rdy;
        bus.jumpValid  = 1'b0;
        bus.jumpTarget = '0;
        @(negedge clk);
        cyc = -1;
        check("rst_valid", 32'(bus.instrValid), 32'd0);
        check("rst_addr",  32'(bus.romAddressOut), 32'd0);
        check("rst_op",    32'(bus.instrOut), 32'd0);
        check("rst_pc",    32'(bus.instrPcOut), 32'd0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic expect_instr(input string tag, input logic [3:0] pc);
        check({tag, "_valid"}, 32'(bus.instrValid), 32'd1);
        check({tag, "_pc"},    32'(bus.instrPcOut), 32'(pc));
        check({tag, "_op"},    32'(bus.instrOut), 32'(rom(pc)));
    endtask

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        cyc            = 0;
        reset          = 1'b1;
        bus.runIn      = 1'b0;
        bus.instrReady = 1'b0;
        bus.jumpValid  = 1'b0;
        bus.jumpTarget = '0;

        // Streaming and wrap: cycle c shows pc (c-2) mod 16
        start(1'b1, 1'b1);
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c == 1) check("stream_empty", 32'(bus.instrValid), 32'd0);
            else        expect_instr("stream", 4'(c - 2));
        end

        // Backpressure: issue stops at 2, head held, release drains in order
        start(1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c >= 2 && c <= 3) expect_instr("bp_hold", 4'd0);
            if (c >= 3 && c <= 4) check("bp_addr", 32'(bus.romAddressOut), 32'd2);
            if (c >= 4) expect_instr("bp_drain", 4'(c - 4));
            if (c == 4) bus.instrReady = 1'b1;
        end

        // Jump to 2 in cycle 4
        start(1'b1, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c >= 2 && c <= 4) expect_instr("pre_jump", 4'(c - 2));
            if (c == 5) check("jump_addr", 32'(bus.romAddressOut), 32'd2);
            if (c == 5 || c == 6) check("jump_gap", 32'(bus.instrValid), 32'd0);
            if (c >= 7) expect_instr("post_jump", 4'(c - 5));
            if (c == 4) begin
                bus.jumpValid  = 1'b1;
                bus.jumpTarget = 4'd2;
            end else begin
                bus.jumpValid  = 1'b0;
            end
        end

        // Halt for cycles 3-5
        start(1'b1, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c >= 4 && c <= 6) check("halt_addr", 32'(bus.romAddressOut), 32'd3);
            if (c >= 2 && c <= 4) expect_instr("pre_halt", 4'(c - 2));
            if (c >= 5 && c <= 7) check("halt_gap", 32'(bus.instrValid), 32'd0);
            if (c >= 8) expect_instr("resume", 4'(c - 5));
            if (c == 3) bus.runIn = 1'b0;
            if (c == 6) bus.runIn = 1'b1;
        end

        // Reset mid-stream with the FIFO full
        start(1'b1, 1'b0);
        for (int c = 1; c <= 3; c++) step();
        check("full_occ", 32'(dut.occupancy), 32'd2);
        expect_instr("full_head", 4'd0);
        reset = 1'b1;
        step();
        check("mid_rst_valid", 32'(bus.instrValid), 32'd0);
        check("mid_rst_addr",  32'(bus.romAddressOut), 32'd0);
        reset          = 1'b0;
        bus.instrReady = 1'b1;
        cyc            = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 1) check("restart_empty", 32'(bus.instrValid), 32'd0);
            else        expect_instr("restart", 4'(c - 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
